mips_fetch_stage: RTL and testbench



---
 rtl/mips_fetch_stage.sv | 85 ++++++++
 tb/tb_mips_fetch_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage
//   Instruction-fetch stage of the pipelined MIPS32 core. Owns the PC, drives
//   the combinational instruction memory and captures the returned word into
//   the IF/ID register. Supports hazard stalls, EX-stage redirects with flush,
//   and a HALT opcode that freezes fetch until a redirect or reset.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   synchronous active-low reset
//   stall         in   hold PC, IF/ID and state
//   branch_taken  in   redirect request (overrides stall, exits HALTED)
//   branch_target in   redirect byte address (low 2 bits ignored)
//   imem_addr     out  byte address to instruction memory (= pc)
//   imem_instr    in   instruction word for imem_addr
//   if_id_instr   out  IF/ID instruction
//   if_id_npc     out  IF/ID PC+4
//   if_id_valid   out  IF/ID holds a real instruction
//   halted        out  fetch frozen by HALT
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid,
    output logic        halted
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        is_halt;

    assign imem_addr = pc;
    assign halted    = (state == S_HALTED);
    assign pc_plus4  = pc + 32'd4;   // wraps modulo 2^32
    assign is_halt   = (imem_instr[31:26] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_npc   <= 32'h0;
            if_id_valid <= 1'b0;
            state       <= S_RUN;
        end else if (branch_taken) begin
            // Redirect flushes whatever is on imem_instr, HALT included.
            pc          <= {branch_target[31:2], 2'b00};
            if_id_instr <= 32'h0;
            if_id_npc   <= 32'h0;
            if_id_valid <= 1'b0;
            state       <= S_RUN;
        end else if (!stall) begin
            case (state)
                S_RUN: begin
                    // HALT still flows down the pipe; only the PC freezes.
                    if_id_instr <= imem_instr;
                    if_id_npc   <= pc_plus4;
                    if_id_valid <= 1'b1;
                    if (is_halt) begin
                        state <= S_HALTED;
                    end else begin
                        pc <= pc_plus4;
                    end
                end
                default: begin
                    if_id_instr <= 32'h0;
                    if_id_npc   <= 32'h0;
                    if_id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic        halted;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    mips_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_id_instr  (if_id_instr),
        .if_id_npc    (if_id_npc),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    // Instruction memory: a few fixed words, every other address returns an
    // opcode-0 word equal to its own address (never HALT).
    always_comb begin
        case (imem_addr)
            32'h0000_0000: imem_instr = 32'h2001_0005;
            32'h0000_0004: imem_instr = 32'h2002_0007;
            32'h0000_0008: imem_instr = 32'h0022_1820;
            32'h0000_000C: imem_instr = 32'hFC00_0000;
            default:       imem_instr = {6'b0, imem_addr[25:0]};
        endcase
    end

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_valid;
        logic        e_halt;
        logic [31:0] e_addr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic [31:0] ei,
                                logic [31:0] en, logic ev, logic eh, logic [31:0] ea);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.e_instr = ei; v.e_npc = en;
        v.e_valid = ev; v.e_halt = eh; v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_all(int idx, logic [31:0] ei, logic [31:0] en, logic ev,
                             logic eh, logic [31:0] ea);
        vectors++;
        chk("if_id_instr", idx, if_id_instr, ei);
        chk("if_id_npc",   idx, if_id_npc,   en);
        chk("if_id_valid", idx, {31'b0, if_id_valid}, {31'b0, ev});
        chk("halted",      idx, {31'b0, halted},      {31'b0, eh});
        chk("imem_addr",   idx, imem_addr,   ea);
    endtask

    initial begin
        //                stall br  target        instr          npc           v     h     addr
        vecs[0]  = mk(0, 0, 32'h0,        32'h2001_0005, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0004);
        vecs[1]  = mk(0, 0, 32'h0,        32'h2002_0007, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0008);
        vecs[2]  = mk(1, 0, 32'h0,        32'h2002_0007, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0008);
        vecs[3]  = mk(1, 0, 32'h0,        32'h2002_0007, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0008);
        vecs[4]  = mk(1, 0, 32'h0,        32'h2002_0007, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0008);
        vecs[5]  = mk(0, 0, 32'h0,        32'h0022_1820, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_000C);
        vecs[6]  = mk(0, 0, 32'h0,        32'hFC00_0000, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_000C);
        vecs[7]  = mk(0, 0, 32'h0,        32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_000C);
        vecs[8]  = mk(1, 0, 32'h0,        32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_000C);
        vecs[9]  = mk(0, 0, 32'h0,        32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_000C);
        vecs[10] = mk(0, 1, 32'h20,       32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0020);
        vecs[11] = mk(0, 0, 32'h0,        32'h0000_0020, 32'h0000_0024, 1'b1, 1'b0, 32'h0000_0024);
        vecs[12] = mk(1, 1, 32'h43,       32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0040);
        vecs[13] = mk(0, 0, 32'h0,        32'h0000_0040, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0044);
        vecs[14] = mk(0, 1, 32'hFFFF_FFFC, 32'h0,        32'h0,         1'b0, 1'b0, 32'hFFFF_FFFC);
        vecs[15] = mk(0, 0, 32'h0,        32'h03FF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000);
        vecs[16] = mk(0, 0, 32'h0,        32'h2001_0005, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0004);
        vecs[17] = mk(0, 1, 32'h0C,       32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_000C);
        // HALT word on imem_instr is discarded by the redirect.
        vecs[18] = mk(0, 1, 32'h08,       32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0008);
        vecs[19] = mk(0, 0, 32'h0,        32'h0022_1820, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_000C);
        vecs[20] = mk(0, 0, 32'h0,        32'hFC00_0000, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_000C);

        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall;
            branch_taken = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].e_instr, vecs[i].e_npc, vecs[i].e_valid,
                      vecs[i].e_halt, vecs[i].e_addr);
            @(negedge clk);
        end

        // Reset while HALTED and stalled returns everything to reset values.
        stall = 1'b1; branch_taken = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all(100, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Stall asserted during reset does not outlive it; fetch restarts at 0.
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        @(posedge clk);
        #1;
        check_all(101, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 32'h4);

        // Branch with a misaligned target wins over stall and clears HALT path.
        @(negedge clk);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_000F;
        @(posedge clk);
        #1;
        check_all(102, 32'h0, 32'h0, 1'b0, 1'b0, 32'hC);
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        check_all(103, 32'hFC00_0000, 32'h10, 1'b1, 1'b1, 32'hC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
